// File: rtl/ravan_cipher_core.sv
// RAVAN iterative block-cipher core: one encrypt or decrypt round per clock,
// key whitening on entry and exit, valid/ready handshakes on both sides.
module ravan_cipher_core #(
  parameter int unsigned DW     = 64,
  parameter int unsigned KW     = 512,
  parameter int unsigned ROUNDS = 21,
  parameter int unsigned ROT    = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_mode,
  input  logic [KW-1:0] key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy
);

  localparam int unsigned NK = KW / DW;
  localparam int unsigned IW = $clog2(NK);
  localparam int unsigned RW = $clog2(ROUNDS + 1);

  localparam logic [IW-1:0] IDX_LAST = IW'(NK - 1);
  localparam logic [IW-1:0] DEC_IA0  = IW'((ROUNDS - 1) % NK);
  localparam logic [IW-1:0] DEC_IB0  = IW'(ROUNDS % NK);
  localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] t_q;
  logic [KW-1:0] key_q;
  logic          mode_q;
  logic [IW-1:0] ia_q;
  logic [IW-1:0] ib_q;
  logic [RW-1:0] rnd_q;

  logic [DW-1:0] ka;
  logic [DW-1:0] kb;
  logic [DW-1:0] enc_t;
  logic [DW-1:0] dec_t;
  logic [DW-1:0] t_next;
  logic [DW-1:0] w0_in;
  logic [DW-1:0] w1_in;
  logic [DW-1:0] w0_q;
  logic [DW-1:0] w1_q;
  logic [DW-1:0] start_t;
  logic [DW-1:0] final_t;
  logic          last_round;
  logic [IW-1:0] ia_inc;
  logic [IW-1:0] ib_inc;
  logic [IW-1:0] ia_dec;
  logic [IW-1:0] ib_dec;

  function automatic logic [DW-1:0] rotl(input logic [DW-1:0] x);
    return (x << ROT) | (x >> (DW - ROT));
  endfunction

  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] x);
    return (x >> ROT) | (x << (DW - ROT));
  endfunction

  always_comb begin
    ka      = key_q[ia_q*DW +: DW];
    kb      = key_q[ib_q*DW +: DW];
    enc_t   = rotl((t_q ^ ka) + kb);
    dec_t   = (rotr(t_q) - kb) ^ ka;
    t_next  = mode_q ? dec_t : enc_t;

    w0_in   = key[0 +: DW] ^ key[(NK-1)*DW +: DW];
    w1_in   = ~key[DW +: DW];
    w0_q    = key_q[0 +: DW] ^ key_q[(NK-1)*DW +: DW];
    w1_q    = ~key_q[DW +: DW];
    start_t = in_data ^ (in_mode ? w1_in : w0_in);
    // The last round and the exit whitening land in the same cycle.
    final_t = t_next ^ (mode_q ? w0_q : w1_q);

    last_round = mode_q ? (rnd_q == '0) : (rnd_q == RND_LAST);

    ia_inc = (ia_q == IDX_LAST) ? '0 : ia_q + IW'(1);
    ib_inc = (ib_q == IDX_LAST) ? '0 : ib_q + IW'(1);
    ia_dec = (ia_q == '0) ? IDX_LAST : ia_q - IW'(1);
    ib_dec = (ib_q == '0) ? IDX_LAST : ib_q - IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      t_q       <= '0;
      key_q     <= '0;
      mode_q    <= 1'b0;
      ia_q      <= '0;
      ib_q      <= '0;
      rnd_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            t_q      <= start_t;
            key_q    <= key;
            mode_q   <= in_mode;
            if (in_mode) begin
              ia_q  <= DEC_IA0;
              ib_q  <= DEC_IB0;
              rnd_q <= RND_LAST;
            end else begin
              ia_q  <= '0;
              ib_q  <= IW'(1);
              rnd_q <= '0;
            end
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          t_q <= t_next;
          if (mode_q) begin
            ia_q  <= ia_dec;
            ib_q  <= ib_dec;
            rnd_q <= rnd_q - RW'(1);
          end else begin
            ia_q  <= ia_inc;
            ib_q  <= ib_inc;
            rnd_q <= rnd_q + RW'(1);
          end
          if (last_round) begin
            out_data  <= final_t;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ravan_cipher_core.sv
// Bench for ravan_cipher_core: three configurations checked against known
// answers and a spec-level reference model, plus handshake corner cases.
module tb_ravan_cipher_core;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv[3];
  logic         im[3];
  logic         ordy[3];
  logic [63:0]  id[3];
  logic [511:0] ik[3];

  logic        ir0, ir1, ir2, ov0, ov1, ov2, bz0, bz1, bz2;
  logic [63:0] od0, od1;
  logic [31:0] od2;

  logic        ir[3];
  logic        ov[3];
  logic        bz[3];
  logic [63:0] od[3];

  always_comb begin
    ir[0] = ir0; ir[1] = ir1; ir[2] = ir2;
    ov[0] = ov0; ov[1] = ov1; ov[2] = ov2;
    bz[0] = bz0; bz[1] = bz1; bz[2] = bz2;
    od[0] = od0; od[1] = od1; od[2] = {32'd0, od2};
  end

  int cdw [3] = '{64, 64, 32};
  int cnk [3] = '{8, 8, 4};
  int crnd[3] = '{21, 1, 7};
  int crot[3] = '{13, 13, 5};

  int checks = 0;
  int errors = 0;

  ravan_cipher_core u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .in_data(id[0]),
    .in_mode(im[0]), .key(ik[0]), .out_valid(ov0), .out_ready(ordy[0]),
    .out_data(od0), .busy(bz0)
  );

  ravan_cipher_core #(.ROUNDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .in_data(id[1]),
    .in_mode(im[1]), .key(ik[1]), .out_valid(ov1), .out_ready(ordy[1]),
    .out_data(od1), .busy(bz1)
  );

  ravan_cipher_core #(.DW(32), .KW(128), .ROUNDS(7), .ROT(5)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .in_data(id[2][31:0]),
    .in_mode(im[2]), .key(ik[2][127:0]), .out_valid(ov2), .out_ready(ordy[2]),
    .out_data(od2), .busy(bz2)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] mask_of(input int dw);
    return (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw) - 64'd1);
  endfunction

  function automatic logic [63:0] m_rotl(input logic [63:0] x, input int dw, input int rot);
    return ((x << rot) | (x >> (dw - rot))) & mask_of(dw);
  endfunction

  function automatic logic [63:0] m_rotr(input logic [63:0] x, input int dw, input int rot);
    return ((x >> rot) | (x << (dw - rot))) & mask_of(dw);
  endfunction

  function automatic logic [63:0] ref_cipher(input bit dec, input logic [511:0] k,
                                             input logic [63:0] d, input int s);
    logic [63:0]  m, t, w0, w1;
    logic [63:0]  ks[8];
    logic [511:0] sh;
    int dw, nk, rounds, rot;
    dw = cdw[s]; nk = cnk[s]; rounds = crnd[s]; rot = crot[s];
    m = mask_of(dw);
    for (int j = 0; j < nk; j++) begin
      sh    = k >> (j * dw);
      ks[j] = sh[63:0] & m;
    end
    w0 = ks[0] ^ ks[nk-1];
    w1 = ~ks[1] & m;
    if (!dec) begin
      t = (d & m) ^ w0;
      for (int r = 0; r < rounds; r++)
        t = m_rotl(((t ^ ks[r % nk]) + ks[(r + 1) % nk]) & m, dw, rot);
      return t ^ w1;
    end else begin
      t = (d & m) ^ w1;
      for (int r = rounds - 1; r >= 0; r--)
        t = ((m_rotr(t, dw, rot) - ks[(r + 1) % nk]) & m) ^ ks[r % nk];
      return t ^ w0;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] rnd_key();
    logic [511:0] k;
    for (int j = 0; j < 16; j++) k[j*32 +: 32] = $urandom;
    return k;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic scramble(input int s);
    id[s]   = rnd64();
    ik[s]   = rnd_key();
    im[s]   = 1'($urandom);
    iv[s]   = 1'($urandom);
    ordy[s] = 1'($urandom);
  endtask

  // Returns just after the handshake edge.
  task automatic start(input int s, input bit mode, input logic [511:0] k, input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!ir[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_start", 64'(ir[s]), 64'd1);
    iv[s] = 1'b1; im[s] = mode; ik[s] = k; id[s] = d;
    @(posedge clk);
    #1 iv[s] = 1'b0;
  endtask

  // Scrambles all inputs every cycle while waiting; n = edges after handshake.
  task automatic wait_out(input int s, output logic [63:0] res, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (ov[s]) break;
      if (n >= 100) begin
        check("out_valid_timeout", 64'(ov[s]), 64'd1);
        break;
      end
      check("in_ready_low_run", 64'(ir[s]), 64'd0);
      check("busy_run", 64'(bz[s]), 64'd1);
      scramble(s);
      @(posedge clk);
      n++;
    end
    iv[s] = 1'b0;
    ordy[s] = 1'b0;
    check("in_ready_with_valid", 64'(ir[s]), 64'd0);
    res = od[s];
  endtask

  task automatic accept(input int s);
    ordy[s] = 1'b1;
    @(posedge clk);
    #1 ordy[s] = 1'b0;
    @(negedge clk);
    check("out_valid_after_accept", 64'(ov[s]), 64'd0);
    check("in_ready_after_accept", 64'(ir[s]), 64'd1);
    check("busy_after_accept", 64'(bz[s]), 64'd0);
  endtask

  task automatic run(input int s, input bit mode, input logic [511:0] k,
                     input logic [63:0] d, output logic [63:0] res);
    int n;
    start(s, mode, k, d);
    wait_out(s, res, n);
    check("latency", 64'(n), 64'(crnd[s]));
    accept(s);
  endtask

  typedef struct {
    int           s;
    bit           mode;
    logic [511:0] key;
    logic [63:0]  din;
    logic [63:0]  dout;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [511:0] k;
    logic [63:0]  d, res, back, m;
    int           n;
    bit           stale;

    tbl[0] = '{0, 1'b0, 512'd0, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFD_FFFF};
    tbl[1] = '{0, 1'b1, 512'd0, 64'hFFFF_FFFF_FFFD_FFFF, 64'h0000_0000_0000_0001};
    tbl[2] = '{1, 1'b0, 512'd1, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_DFFF};
    tbl[3] = '{1, 1'b1, 512'd1, 64'hFFFF_FFFF_FFFF_DFFF, 64'h0000_0000_0000_0001};

    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      iv[s] = 1'b0; im[s] = 1'b0; ordy[s] = 1'b0; id[s] = '0; ik[s] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("reset_out_valid", 64'(ov[s]), 64'd0);
      check("reset_out_data", od[s], 64'd0);
      check("reset_busy", 64'(bz[s]), 64'd0);
      check("reset_in_ready", 64'(ir[s]), 64'd1);
    end
    rst = 1'b1;

    // Known-answer vectors
    for (int i = 0; i < 4; i++) begin
      run(tbl[i].s, tbl[i].mode, tbl[i].key, tbl[i].din, res);
      check("kat", res, tbl[i].dout);
    end

    // Random round trips against the model
    for (int s = 0; s < 3; s++) begin
      m = mask_of(cdw[s]);
      for (int i = 0; i < ((s == 0) ? 200 : (s == 1) ? 40 : 100); i++) begin
        k = rnd_key();
        d = rnd64() & m;
        run(s, 1'b0, k, d, res);
        check("rand_enc", res, ref_cipher(1'b0, k, d, s));
        run(s, 1'b1, k, res, back);
        check("rand_dec", back, d);
      end
    end

    // Backpressure: hold 10 cycles with in_valid pulses that must be ignored
    k = rnd_key();
    d = rnd64();
    start(0, 1'b0, k, d);
    wait_out(0, res, n);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 iv[0] = 1'($urandom); id[0] = rnd64(); im[0] = 1'($urandom); ik[0] = rnd_key();
      @(negedge clk);
      check("hold_data", od[0], res);
      check("hold_valid", 64'(ov[0]), 64'd1);
      check("hold_in_ready", 64'(ir[0]), 64'd0);
      check("hold_busy", 64'(bz[0]), 64'd1);
    end
    iv[0] = 1'b0;
    check("hold_result", res, ref_cipher(1'b0, k, d, 0));
    accept(0);

    // Reset at round 10 aborts the block
    k = rnd_key();
    d = rnd64();
    start(0, 1'b0, k, d);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_out_valid", 64'(ov[0]), 64'd0);
    check("abort_busy", 64'(bz[0]), 64'd0);
    check("abort_in_ready", 64'(ir[0]), 64'd1);
    rst = 1'b1;
    stale = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ov[0]) stale = 1'b1;
    end
    check("abort_no_stale", 64'(stale), 64'd0);
    k = rnd_key();
    d = rnd64();
    run(0, 1'b1, k, d, res);
    check("post_abort_dec", res, ref_cipher(1'b1, k, d, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
